// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// PIPE_FWD_EN selects forwarding; without it every in-flight writer stalls.
package pipe_pkg;

    // Widest register number a scoreboard slot can hold; narrower ids are zero-extended.
    localparam int REG_ADDR_MAX_W = 8;

    localparam int FWD_REGFILE    = 0;
    localparam int ALU_READY_SLOT = 2;

    localparam logic [REG_ADDR_MAX_W-1:0] REG_ZERO = '0;

`ifdef PIPE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic                      valid;
        logic                      wr_en;
        logic [REG_ADDR_MAX_W-1:0] wr_reg;
        logic                      is_load;
    } sb_slot_t;

    // Slot at whose output a producer's result first exists.
    function automatic int ready_slot(input logic is_load, input int load_ready);
        return is_load ? load_ready : ALU_READY_SLOT;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-side bus between the decode stage and the hazard unit.
// Widths follow the unit's REG_ADDR_W, DEPTH and CNT_W.
interface pipe_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_wr_en;
    logic [REG_ADDR_W-1:0] id_wr_reg;
    logic                  id_is_load;
    logic                  ex_redirect;

    logic                  stall;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic [FW-1:0]         fwd_a_sel;
    logic [FW-1:0]         fwd_b_sel;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, ex_redirect,
        input  stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, ex_redirect,
        output stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_count
    );

endinterface

// File: rtl/pipe_hazard_unit_sb_match.sv
// Youngest-match priority encoder over the checked scoreboard slots for one source.
// Hazard rule depends on PIPE_FWD_EN (via pipe_pkg::FWD_EN).
module sb_match
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int REG_ADDR_W = 5,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  sb_slot_t              i_slots [1:DEPTH-1],
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_use,
    output logic                  o_hazard,
    output logic [FW-1:0]         o_sel
);

    logic [REG_ADDR_MAX_W-1:0] w_src;
    int                        w_ready;

    // NOTE: every output gets a default before the loop so no path infers a latch.
    always_comb begin
        w_src    = REG_ADDR_MAX_W'(i_src);
        w_ready  = 0;
        o_hazard = 1'b0;
        o_sel    = '0;
        // Oldest to youngest, so the youngest match overwrites the others.
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (i_use && w_src != REG_ZERO && i_slots[k].valid &&
                i_slots[k].wr_en && i_slots[k].wr_reg == w_src) begin
                // Without forwarding nothing is ready before the writer leaves slot DEPTH-1.
                w_ready  = FWD_EN ? ready_slot(i_slots[k].is_load, LOAD_READY) : DEPTH + 1;
                o_hazard = (k + 1) < w_ready;
                o_sel    = FWD_EN ? FW'(k + 1) : FW'(FWD_REGFILE);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard-control unit: scoreboard of in-flight writers, load-use stall, redirect flushes
// and registered EX forwarding selects. Forwarding is enabled by PIPE_FWD_EN.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int CNT_W      = 16,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                reset,
    pipe_hazard_unit_if.slave  bus
);

    // Slot DEPTH is never checked (write-before-read register file), so it is not stored.
    sb_slot_t          r_sb [1:DEPTH-1];
    logic [FW-1:0]     r_fwd_a_sel;
    logic [FW-1:0]     r_fwd_b_sel;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_haz_a;
    logic              w_haz_b;
    logic [FW-1:0]     w_sel_a;
    logic [FW-1:0]     w_sel_b;
    logic              w_stall;
    logic              w_advance;
    sb_slot_t          w_new_slot;

    sb_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_ADDR_W(REG_ADDR_W), .FW(FW)) u_match_rs (
        .i_slots  (r_sb),
        .i_src    (bus.id_rs),
        .i_use    (bus.id_use_rs),
        .o_hazard (w_haz_a),
        .o_sel    (w_sel_a)
    );

    sb_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_ADDR_W(REG_ADDR_W), .FW(FW)) u_match_rt (
        .i_slots  (r_sb),
        .i_src    (bus.id_rt),
        .i_use    (bus.id_use_rt),
        .o_hazard (w_haz_b),
        .o_sel    (w_sel_b)
    );

    // The redirect wins over a stall; reset masks both straight away.
    always_comb begin
        w_stall    = !reset && bus.id_valid && (w_haz_a || w_haz_b) && !bus.ex_redirect;
        w_advance  = bus.id_valid && !w_stall && !bus.ex_redirect;
        w_new_slot = '0;
        if (w_advance) begin
            w_new_slot.valid   = 1'b1;
            w_new_slot.wr_en   = bus.id_wr_en;
            w_new_slot.wr_reg  = REG_ADDR_MAX_W'(bus.id_wr_reg);
            w_new_slot.is_load = bus.id_is_load;
        end
    end

    // NOTE: the scoreboard is cleared on reset because a stale valid bit would raise a phantom stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH - 1; k++) begin
                r_sb[k] <= '0;
            end
            r_fwd_a_sel   <= '0;
            r_fwd_b_sel   <= '0;
            r_stall_count <= '0;
        end else begin
            // NOTE: non-blocking so each slot takes its neighbour's pre-edge value.
            r_sb[1] <= w_new_slot;
            for (int k = 2; k <= DEPTH - 1; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_fwd_a_sel <= w_advance ? w_sel_a : FW'(FWD_REGFILE);
            r_fwd_b_sel <= w_advance ? w_sel_b : FW'(FWD_REGFILE);
            if (w_stall && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.flush_if_id = !reset && bus.ex_redirect;
    assign bus.flush_id_ex = !reset && bus.ex_redirect;
    assign bus.fwd_a_sel   = r_fwd_a_sel;
    assign bus.fwd_b_sel   = r_fwd_b_sel;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit; expectations adapt to PIPE_FWD_EN.
// Forwarding selects are scoreboarded: pushed when ID is driven, popped one edge later.
module tb_pipe_hazard_unit;

    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 3;
    localparam int RW         = 5;
    localparam int CW         = 4;
    localparam int FW         = $clog2(DEPTH + 1);

`ifdef PIPE_FWD_EN
    localparam bit M_FWD         = 1'b1;
    localparam int EXP_ALU_STALL = 0;
    localparam int EXP_LD_STALL  = LOAD_READY - 2;
    localparam int EXP_RDR_STALL = 0;
`else
    localparam bit M_FWD         = 1'b0;
    localparam int EXP_ALU_STALL = DEPTH - 1;
    localparam int EXP_LD_STALL  = DEPTH - 1;
    localparam int EXP_RDR_STALL = 1;
`endif

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          urs;
        logic          urt;
        logic          we;
        logic [RW-1:0] rd;
        logic          ld;
    } ins_t;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [RW-1:0] rd;
        logic          ld;
    } m_ent_t;

    logic clk;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    m_ent_t          m_hist [DEPTH];
    logic [CW-1:0]   m_cnt;
    logic [2*FW-1:0] exp_fwd_q [$];

    pipe_hazard_unit_if #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .CNT_W(CW)) bus ();

    pipe_hazard_unit #(
        .REG_ADDR_W (RW),
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t alu(input int rd, input int rs, input int rt);
        ins_t i;
        i = '{v: 1'b1, rs: RW'(rs), rt: RW'(rt), urs: 1'b1, urt: 1'b1,
              we: 1'b1, rd: RW'(rd), ld: 1'b0};
        return i;
    endfunction

    function automatic ins_t lw(input int rd, input int base);
        ins_t i;
        i = '{v: 1'b1, rs: RW'(base), rt: '0, urs: 1'b1, urt: 1'b0,
              we: 1'b1, rd: RW'(rd), ld: 1'b1};
        return i;
    endfunction

    // Model: scan from the youngest in-flight instruction towards the oldest checked one.
    task automatic m_lookup(input logic [RW-1:0] src, input logic use_f,
                            output logic haz, output logic [FW-1:0] sel);
        logic found;
        int   ready;
        haz   = 1'b0;
        sel   = '0;
        found = 1'b0;
        if (use_f && src != 0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (!found && m_hist[i].v && m_hist[i].we && m_hist[i].rd == src) begin
                    found = 1'b1;
                    if (M_FWD) begin
                        ready = m_hist[i].ld ? LOAD_READY : 2;
                        haz   = (i + 2) < ready;
                        sel   = FW'(i + 2);
                    end else begin
                        haz = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive_cycle(input logic rst, input ins_t in, input logic redir, output logic st);
        logic            ha, hb, es, ef, adv;
        logic [FW-1:0]   sa, sb, ea, eb;
        logic [2*FW-1:0] popped;
        reset           = rst;
        bus.id_valid    = in.v;
        bus.id_rs       = in.rs;
        bus.id_rt       = in.rt;
        bus.id_use_rs   = in.urs;
        bus.id_use_rt   = in.urt;
        bus.id_wr_en    = in.we;
        bus.id_wr_reg   = in.rd;
        bus.id_is_load  = in.ld;
        bus.ex_redirect = redir;
        #2;
        m_lookup(in.rs, in.urs, ha, sa);
        m_lookup(in.rt, in.urt, hb, sb);
        es  = !rst && in.v && (ha || hb) && !redir;
        ef  = !rst && redir;
        adv = in.v && !es && !redir;
        check("stall", bus.stall, es);
        check("flush_if_id", bus.flush_if_id, ef);
        check("flush_id_ex", bus.flush_id_ex, ef);
        exp_fwd_q.push_back((adv && !rst) ? {sa, sb} : '0);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_hist[i] = '0;
            m_cnt = '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = adv ? '{v: 1'b1, we: in.we, rd: in.rd, ld: in.ld} : '0;
            if (es && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        popped = exp_fwd_q.pop_front();
        {ea, eb} = popped;
        check("fwd_a_sel", bus.fwd_a_sel, ea);
        check("fwd_b_sel", bus.fwd_b_sel, eb);
        check("stall_count", bus.stall_count, m_cnt);
        st = es;
    endtask

    // Holds the instruction in ID while it is stalled, as the real pipeline would.
    task automatic issue(input ins_t in, output int stalls);
        logic st;
        stalls = 0;
        drive_cycle(1'b0, in, 1'b0, st);
        while (st && stalls < 8) begin
            stalls++;
            drive_cycle(1'b0, in, 1'b0, st);
        end
        if (st) check("stall_bound", st, 1'b0);
    endtask

    task automatic drain(input int n);
        logic st;
        repeat (n) drive_cycle(1'b0, '0, 1'b0, st);
    endtask

    initial begin
        logic st;
        int   n;
        ins_t r;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_hist[i] = '0;
        m_cnt = '0;

        drive_cycle(1'b1, alu(9, 8, 8), 1'b0, st);
        drive_cycle(1'b1, '0, 1'b0, st);

        // ALU producer then ALU consumer on rs only.
        issue(alu(8, 1, 2), n);
        issue(alu(9, 8, 0), n);
        check("alu_alu_stalls", n, EXP_ALU_STALL);
        drain(3);

        // Load-use on both operands.
        issue(lw(8, 1), n);
        issue(alu(9, 8, 8), n);
        check("load_use_stalls", n, EXP_LD_STALL);
        drain(3);

        // $0 is never a dependency.
        issue(alu(0, 1, 2), n);
        issue(alu(9, 0, 0), n);
        check("zero_reg_stalls", n, 0);
        drain(3);

        // Two writers of $8 in flight: the youngest is the source.
        issue(alu(8, 1, 2), n);
        issue(alu(8, 1, 1), n);
        issue(alu(10, 8, 2), n);
        check("youngest_stalls", n, EXP_ALU_STALL);
        drain(3);

        // Load-use coinciding with a redirect: no stall, flushes, bubble into slot 1.
        issue(lw(8, 1), n);
        drive_cycle(1'b0, alu(8, 8, 2), 1'b1, st);
        issue(alu(9, 8, 2), n);
        check("after_redirect_stalls", n, EXP_RDR_STALL);
        drain(3);

        // Reset arriving while a stall condition is present.
        issue(lw(8, 1), n);
        drive_cycle(1'b1, alu(9, 8, 8), 1'b0, st);
        check("reset_count", bus.stall_count, 0);
        issue(alu(9, 8, 8), n);
        check("post_reset_stalls", n, 0);
        drain(3);

        // Enough load-use pairs to saturate the narrow stall counter.
        for (int i = 0; i < 20; i++) begin
            issue(lw(3, 1), n);
            issue(alu(4, 3, 2), n);
        end
        check("count_saturated", bus.stall_count, 4'hF);
        drain(3);

        // Random mix over a small register range, with occasional redirects.
        for (int i = 0; i < 80; i++) begin
            r.v   = ($urandom_range(0, 4) != 0);
            r.rs  = RW'($urandom_range(0, 3));
            r.rt  = RW'($urandom_range(0, 3));
            r.urs = 1'($urandom_range(0, 1));
            r.urt = 1'($urandom_range(0, 1));
            r.we  = 1'($urandom_range(0, 1));
            r.rd  = RW'($urandom_range(0, 3));
            r.ld  = 1'($urandom_range(0, 1));
            drive_cycle(1'b0, r, ($urandom_range(0, 7) == 0), st);
        end
        drain(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
